// File: rtl/q2_sequencer.sv
// ---------------------------------------------------------------------------
// q2_sequencer
//
// Cycle-state sequencer for the Q2 CPU. Walks each instruction through
// FETCH / DEREF / LOAD / EXEC and an optional multi-step serial ALU state.
// Every state lasts two clocks (phase 0 settle, phase 1 write). The block
// also owns front-panel run/halt/single-step control and turns the DEPOSIT
// switch into a clean one-clock strobe.
//
// Ports:
//   clk, nrst           system clock, asynchronous active-low reset
//   run_sw              panel RUN level (asynchronous)
//   step_sw, dep_sw     panel STEP / DEPOSIT switches, rising edge acts
//   deref, o2           decoded indirect bit and opcode bit 2 (0 = load class)
//   s2in, halt_req      ALU multi-cycle request / halt, sampled at end of EXEC
//   s0/ns0, s1/ns1      state bits and complements
//   s2, s3              ALU shift state active / final ALU shift step
//   ws                  write strobe, phase 1 of every active state
//   running             sequencer executing
//   dep_strobe          one-clock deposit pulse
// ---------------------------------------------------------------------------
module q2_sequencer #(
    parameter int ALU_STEPS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic run_sw,
    input  logic step_sw,
    input  logic dep_sw,
    input  logic deref,
    input  logic o2,
    input  logic s2in,
    input  logic halt_req,
    output logic s0,
    output logic ns0,
    output logic s1,
    output logic ns1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic running,
    output logic dep_strobe
);

    // Encoding is {s2,s1,s0}, so the state bits fall straight out of the register.
    typedef enum logic [2:0] {
        ST_FETCH = 3'b000,
        ST_DEREF = 3'b001,
        ST_LOAD  = 3'b010,
        ST_EXEC  = 3'b011,
        ST_ALU   = 3'b100
    } state_t;

    localparam logic [3:0] StepsInit = 4'(ALU_STEPS - 1);

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic                   running_q, running_d;
    logic                   single_q, single_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   depStrobe_q, depStrobe_d;
    logic [SYNC_STAGES-1:0] runSync_q, stepSync_q, depSync_q;
    logic                   stepPrev_q, depPrev_q;

    logic runLvl, stepLvl, depLvl;
    logic stepEdge, depEdge;
    logic endInstr;

    assign runLvl   = runSync_q[SYNC_STAGES-1];
    assign stepLvl  = stepSync_q[SYNC_STAGES-1];
    assign depLvl   = depSync_q[SYNC_STAGES-1];
    assign stepEdge = stepLvl & ~stepPrev_q;
    assign depEdge  = depLvl & ~depPrev_q;

    // Panel synchronizers and edge-detect history. The history flops update
    // every cycle, so an edge seen while running is consumed, not queued.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            runSync_q  <= '0;
            stepSync_q <= '0;
            depSync_q  <= '0;
            stepPrev_q <= 1'b0;
            depPrev_q  <= 1'b0;
        end else begin
            runSync_q  <= {runSync_q[SYNC_STAGES-2:0], run_sw};
            stepSync_q <= {stepSync_q[SYNC_STAGES-2:0], step_sw};
            depSync_q  <= {depSync_q[SYNC_STAGES-2:0], dep_sw};
            stepPrev_q <= stepLvl;
            depPrev_q  <= depLvl;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_FETCH;
            phase_q     <= 1'b0;
            running_q   <= 1'b0;
            single_q    <= 1'b0;
            cnt_q       <= 4'd0;
            depStrobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            running_q   <= running_d;
            single_q    <= single_d;
            cnt_q       <= cnt_d;
            depStrobe_q <= depStrobe_d;
        end
    end

    // Next-state logic. While halted the sequencer sits frozen in FETCH
    // phase 0 and only panel events act. While running, phase 0 always
    // moves to phase 1 and the state transition happens at the end of
    // phase 1. Run/step stop is only considered at instruction boundaries
    // (EXEC or the last ALU step going back to FETCH); halt_req forces a
    // stop there and also suppresses the ALU state.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        running_d   = running_q;
        single_d    = single_q;
        cnt_d       = cnt_q;
        depStrobe_d = 1'b0;
        endInstr    = 1'b0;

        if (!running_q) begin
            state_d = ST_FETCH;
            phase_d = 1'b0;
            if (stepEdge) begin
                running_d = 1'b1;
                single_d  = 1'b1;
            end else if (runLvl) begin
                running_d = 1'b1;
            end
            if (depEdge && !stepEdge) begin
                depStrobe_d = 1'b1;
            end
        end else if (!phase_q) begin
            phase_d = 1'b1;
        end else begin
            phase_d = 1'b0;
            unique case (state_q)
                ST_FETCH: begin
                    if (deref)    state_d = ST_DEREF;
                    else if (!o2) state_d = ST_LOAD;
                    else          state_d = ST_EXEC;
                end
                ST_DEREF: state_d = o2 ? ST_EXEC : ST_LOAD;
                ST_LOAD:  state_d = ST_EXEC;
                ST_EXEC: begin
                    if (halt_req) begin
                        state_d   = ST_FETCH;
                        running_d = 1'b0;
                        single_d  = 1'b0;
                    end else if (s2in) begin
                        state_d = ST_ALU;
                        cnt_d   = StepsInit;
                    end else begin
                        state_d  = ST_FETCH;
                        endInstr = 1'b1;
                    end
                end
                ST_ALU: begin
                    if (cnt_q == 4'd0) begin
                        state_d  = ST_FETCH;
                        endInstr = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
            if (endInstr && (!runLvl || single_q)) begin
                running_d = 1'b0;
                single_d  = 1'b0;
            end
        end
    end

    // Outputs come straight from registers, so reset clears them at once
    // and ws cannot glitch when nrst falls.
    always_comb begin
        s0         = state_q[0];
        s1         = state_q[1];
        ns0        = ~state_q[0];
        ns1        = ~state_q[1];
        s2         = (state_q == ST_ALU);
        s3         = (state_q == ST_ALU) && (cnt_q == 4'd0);
        ws         = running_q & phase_q;
        running    = running_q;
        dep_strobe = depStrobe_q;
    end

endmodule

// File: tb/tb_q2_sequencer.sv
// ---------------------------------------------------------------------------
// tb_q2_sequencer
//
// Self-checking bench for q2_sequencer. Expected per-cycle output vectors
// are built from the instruction's path through the states (a list of
// two-clock states), not from any register-level description.
// ---------------------------------------------------------------------------
module tb_q2_sequencer;

    localparam int ALU_STEPS   = 8;
    localparam int SYNC_STAGES = 2;
    // {s1,s0,ns1,ns0,s2,s3,ws,running}
    localparam logic [7:0] IDLE = 8'b0011_0000;

    logic clk, nrst;
    logic run_sw, step_sw, dep_sw;
    logic deref, o2, s2in, halt_req;
    logic s0, ns0, s1, ns1, s2, s3, ws, running, dep_strobe;
    logic [7:0] obsVec;

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];

    assign obsVec = {s1, s0, ns1, ns0, s2, s3, ws, running};

    q2_sequencer #(
        .ALU_STEPS  (ALU_STEPS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .run_sw    (run_sw),
        .step_sw   (step_sw),
        .dep_sw    (dep_sw),
        .deref     (deref),
        .o2        (o2),
        .s2in      (s2in),
        .halt_req  (halt_req),
        .s0        (s0),
        .ns0       (ns0),
        .s1        (s1),
        .ns1       (ns1),
        .s2        (s2),
        .s3        (s3),
        .ws        (ws),
        .running   (running),
        .dep_strobe(dep_strobe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One active state = two clocks: settle (ws=0) then write (ws=1).
    function automatic void pushState(input bit b1, input bit b0, input bit b2, input bit b3);
        expQ.push_back({b1, b0, ~b1, ~b0, b2, b3, 1'b0, 1'b1});
        expQ.push_back({b1, b0, ~b1, ~b0, b2, b3, 1'b1, 1'b1});
    endfunction

    // Expected output trace of one instruction, starting at FETCH phase 0.
    function automatic void modelInstr(input bit d, input bit op2, input bit alu, input bit hlt);
        expQ.delete();
        pushState(0, 0, 0, 0);
        if (d)    pushState(0, 1, 0, 0);
        if (!op2) pushState(1, 0, 0, 0);
        pushState(1, 1, 0, 0);
        if (alu && !hlt) begin
            for (int k = 0; k < ALU_STEPS; k++) pushState(0, 0, 1, (k == ALU_STEPS - 1));
        end
    endfunction

    task automatic waitRunning(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (running === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; run_sw = 0; step_sw = 0; dep_sw = 0;
        deref = 0; o2 = 0; s2in = 0; halt_req = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (obsVec !== IDLE || dep_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b dep=%b, expected %b dep=0", obsVec, dep_strobe, IDLE);
        end
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obsVec !== IDLE || dep_strobe !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b dep=%b, expected %b dep=0", i, obsVec, dep_strobe, IDLE);
            end
        end
    endtask

    task automatic test_random_run();
        bit ok;
        bit d, op, a;
        run_sw = 1'b1;
        halt_req = 1'b0;
        waitRunning(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL run_start: running=%b, expected 1 within 30 clocks", running);
        end
        for (int n = 0; n < 12; n++) begin
            if (n > 0) @(negedge clk);
            d  = 1'($urandom_range(0, 1));
            op = 1'($urandom_range(0, 1));
            a  = 1'($urandom_range(0, 1));
            deref = d; o2 = op; s2in = a;
            modelInstr(d, op, a, 1'b0);
            for (int i = 0; i < expQ.size(); i++) begin
                if (i > 0) @(negedge clk);
                checks++;
                if (obsVec !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL run_instr %0d (deref=%b o2=%b s2in=%b) cycle %0d: got %b expected %b",
                             n, d, op, a, i, obsVec, expQ[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        bit d, op;
        @(negedge clk);
        d  = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
        deref = d; o2 = op; s2in = 1'b1; halt_req = 1'b1;
        modelInstr(d, op, 1'b1, 1'b1);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obsVec !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL halt_instr cycle %0d: got %b expected %b", i, obsVec, expQ[i]);
            end
        end
        @(negedge clk);
        halt_req = 1'b0; s2in = 1'b0;
        checks++;
        if (obsVec !== IDLE) begin
            errors++;
            $display("[TB] FAIL halt_stop: got %b expected %b", obsVec, IDLE);
        end
        // run_sw is still on, so the sequencer restarts on the next clock.
        @(negedge clk);
        checks++;
        if (obsVec !== 8'b0011_0001) begin
            errors++;
            $display("[TB] FAIL halt_restart: got %b expected %b", obsVec, 8'b0011_0001);
        end
    endtask

    task automatic test_run_drop();
        deref = 1'b0; o2 = 1'b0; s2in = 1'b0;
        modelInstr(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obsVec !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL run_drop_instr cycle %0d: got %b expected %b", i, obsVec, expQ[i]);
            end
            if (i == 2) run_sw = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec !== IDLE) begin
                errors++;
                $display("[TB] FAIL run_drop_idle cycle %0d: got %b expected %b", j, obsVec, IDLE);
            end
        end
    endtask

    task automatic test_step();
        bit ok;
        bit d, op, a;
        d  = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
        a  = 1'($urandom_range(0, 1));
        deref = d; o2 = op; s2in = a; halt_req = 1'b0;
        step_sw = 1'b1;
        waitRunning(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL step_start: running=%b, expected 1 within 30 clocks", running);
        end
        modelInstr(d, op, a, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (i == 3) step_sw = 1'b0;
            checks++;
            if (obsVec !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL step_instr cycle %0d: got %b expected %b", i, obsVec, expQ[i]);
            end
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec !== IDLE) begin
                errors++;
                $display("[TB] FAIL step_idle cycle %0d: got %b expected %b", j, obsVec, IDLE);
            end
        end
    endtask

    task automatic test_deposit();
        bit ok;
        int cnt;
        run_sw = 1'b0;
        dep_sw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
            if (i == 5) dep_sw = 1'b0;
        end
        checks++;
        if (cnt != 1 || obsVec !== IDLE) begin
            errors++;
            $display("[TB] FAIL dep_halted: pulses=%0d state=%b, expected 1 pulse and %b", cnt, obsVec, IDLE);
        end
        // Deposit while running must be ignored.
        deref = 1'b0; o2 = 1'b1; s2in = 1'b0; halt_req = 1'b0;
        run_sw = 1'b1;
        waitRunning(ok);
        dep_sw = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
            if (i == 6) dep_sw = 1'b0;
        end
        checks++;
        if (!ok || cnt != 0) begin
            errors++;
            $display("[TB] FAIL dep_running: started=%b pulses=%0d, expected started=1 pulses=0", ok, cnt);
        end
        run_sw = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
            if (running === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
        end
        checks++;
        if (!ok || cnt != 0 || obsVec !== IDLE) begin
            errors++;
            $display("[TB] FAIL dep_stop: stopped=%b pulses=%0d state=%b, expected 1 0 %b", ok, cnt, obsVec, IDLE);
        end
    endtask

    task automatic test_step_dep();
        bit ok;
        bit d, op;
        int cnt;
        d  = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
        deref = d; o2 = op; s2in = 1'b0; halt_req = 1'b0;
        step_sw = 1'b1;
        dep_sw = 1'b1;
        cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
            if (running === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL step_dep_start: running=%b, expected 1", running);
        end
        modelInstr(d, op, 1'b0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (dep_strobe === 1'b1) cnt++;
            end
            if (i == 0) begin
                step_sw = 1'b0;
                dep_sw = 1'b0;
            end
            checks++;
            if (obsVec !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL step_dep_instr cycle %0d: got %b expected %b", i, obsVec, expQ[i]);
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (dep_strobe === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || obsVec !== IDLE) begin
            errors++;
            $display("[TB] FAIL step_dep_drop: pulses=%0d state=%b, expected 0 and %b", cnt, obsVec, IDLE);
        end
    endtask

    task automatic test_reset_mid_alu();
        bit ok;
        deref = 1'b0; o2 = 1'b1; s2in = 1'b1; halt_req = 1'b0;
        run_sw = 1'b1;
        waitRunning(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL alu_start: running=%b, expected 1", running);
        end
        modelInstr(1'b0, 1'b1, 1'b1, 1'b0);
        // Index 8 is phase 0 of the third ALU step.
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (obsVec !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL alu_pre_reset cycle %0d: got %b expected %b", i, obsVec, expQ[i]);
            end
        end
        #2;
        nrst = 1'b0;
        run_sw = 1'b0;
        #1;
        checks++;
        if (obsVec !== IDLE || dep_strobe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b dep=%b, expected %b dep=0", obsVec, dep_strobe, IDLE);
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (obsVec !== IDLE) begin
                errors++;
                $display("[TB] FAIL post_reset_idle cycle %0d: got %b expected %b", j, obsVec, IDLE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_random_run();
        test_halt();
        test_run_drop();
        test_step();
        test_deposit();
        test_step_dep();
        test_reset_mid_alu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
